// File: rtl/hes_msg_feeder.sv
// hes_msg_feeder: buffers source bytes in a FIFO and hands them to the HES hash core on M/F_dr/F_rtr, then raises End_of_File.
// Latency: a byte accepted into an empty FIFO is on M one cycle later; one byte per cycle on each side.
// Backpressure: in_ready drops when the FIFO is full (even with a pop that cycle) or on start; F_rtr=0 holds M/F_dr.
// Option macro HES_MSG_FEEDER_PAD_EN: appends one trailer byte msg_len[7:0] after the last data byte, before End_of_File.

// Generic byte FIFO with synchronous flush; caller never pushes when full nor pops when empty.
module hes_msg_fifo #(
   parameter int W     = 8,
   parameter int DEPTH = 8
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    flush,
   input  logic                    wr_vld,
   input  logic [W-1:0]            wr_dat,
   input  logic                    rd_rdy,
   output logic [W-1:0]            rd_dat,
   output logic                    full,
   output logic                    empty,
   output logic [$clog2(DEPTH):0]  count
);
   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] PTR_ONE = 1;

   logic [W-1:0] mem [DEPTH];
   logic [AW:0]  wr_ptr;
   logic [AW:0]  rd_ptr;

   // Extra pointer MSB distinguishes full from empty when the low bits match.
   assign empty  = (wr_ptr == rd_ptr);
   assign full   = (wr_ptr == {~rd_ptr[AW], rd_ptr[AW-1:0]});
   assign count  = wr_ptr - rd_ptr;
   assign rd_dat = mem[rd_ptr[AW-1:0]];

   // Pointer update; flush empties the FIFO without touching storage.
   always_ff @(posedge clk) begin
      if (rst || flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (wr_vld) wr_ptr <= wr_ptr + PTR_ONE;
         if (rd_rdy) rd_ptr <= rd_ptr + PTR_ONE;
      end
   end

   // Storage write.
   always_ff @(posedge clk) begin
      if (wr_vld) mem[wr_ptr[AW-1:0]] <= wr_dat;
   end
endmodule

module hes_msg_feeder #(
   parameter int DEPTH = 8,
   parameter int CW    = 16
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          start,
   input  logic          in_valid,
   input  logic [7:0]    in_data,
   input  logic          in_last,
   output logic          in_ready,
   output logic [7:0]    M,
   output logic          F_dr,
   input  logic          F_rtr,
   output logic          End_of_File,
   output logic [CW-1:0] msg_len
);
   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0]   CNT_ONE = 1;
   localparam logic [CW-1:0] LEN_ONE = 1;

   typedef enum logic [2:0] {
      S_IDLE,
      S_LOAD,
      S_DRAIN,
`ifdef HES_MSG_FEEDER_PAD_EN
      S_PAD,
`endif
      S_EOF
   } state_t;

   state_t       state;
   state_t       state_nxt;
   logic         push;
   logic         pop;
   logic         fifo_side;
   logic         full;
   logic         empty;
   logic [7:0]   fifo_dat;
   logic [AW:0]  fifo_cnt;

   hes_msg_fifo #(.W(8), .DEPTH(DEPTH)) u_fifo (
      .clk    (clk),
      .rst    (rst),
      .flush  (start),
      .wr_vld (push),
      .wr_dat (in_data),
      .rd_rdy (pop),
      .rd_dat (fifo_dat),
      .full   (full),
      .empty  (empty),
      .count  (fifo_cnt)
   );

   assign push = in_valid & in_ready;
   assign pop  = fifo_side & F_dr & F_rtr;

   // Next state and outputs; LOAD/DRAIN expose the FIFO head, PAD exposes the length trailer.
   always_comb begin
      state_nxt   = state;
      in_ready    = 1'b0;
      F_dr        = 1'b0;
      M           = 8'h00;
      End_of_File = 1'b0;
      fifo_side   = 1'b0;
      case (state)
         S_IDLE: begin
            state_nxt = S_IDLE;
         end
         S_LOAD: begin
            fifo_side = 1'b1;
            in_ready  = !full && !start;
            if (in_valid && !full && in_last) state_nxt = S_DRAIN;
         end
         S_DRAIN: begin
            fifo_side = 1'b1;
            // Leave on the edge that pops the last entry so End_of_File follows the final transfer directly.
            if (empty || (F_rtr && fifo_cnt == CNT_ONE)) begin
`ifdef HES_MSG_FEEDER_PAD_EN
               state_nxt = S_PAD;
`else
               state_nxt = S_EOF;
`endif
            end
         end
`ifdef HES_MSG_FEEDER_PAD_EN
         S_PAD: begin
            F_dr = 1'b1;
            M    = msg_len[7:0];
            if (F_rtr) state_nxt = S_EOF;
         end
`endif
         S_EOF: begin
            End_of_File = 1'b1;
         end
         default: begin
            state_nxt = S_IDLE;
         end
      endcase
      if (fifo_side) begin
         F_dr = !empty;
         M    = fifo_dat;
      end
      if (start) state_nxt = S_LOAD;
   end

   // State register and accepted-byte counter; start clears the count for the new message.
   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= S_IDLE;
         msg_len <= '0;
      end else begin
         state <= state_nxt;
         if (start)     msg_len <= '0;
         else if (push) msg_len <= msg_len + LEN_ONE;
      end
   end
endmodule

// File: tb/tb_hes_msg_feeder.sv
module tb_hes_msg_feeder;
   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start = 1'b0;
   logic        in_valid = 1'b0;
   logic [7:0]  in_data = 8'h00;
   logic        in_last = 1'b0;
   logic        in_ready;
   logic [7:0]  M;
   logic        F_dr;
   logic        F_rtr = 1'b0;
   logic        End_of_File;
   logic [15:0] msg_len;

   int total = 0;
   int bad = 0;

   logic [7:0] msg_q[$];
   logic [7:0] rx_q[$];
   logic [7:0] exp_q[$];
   int first_acc, first_xfer, last_xfer, eof_cyc;
   bit both_hi, timeout, rdy_after_last;

   hes_msg_feeder #(.DEPTH(8), .CW(16)) dut (
      .clk         (clk),
      .rst         (rst),
      .start       (start),
      .in_valid    (in_valid),
      .in_data     (in_data),
      .in_last     (in_last),
      .in_ready    (in_ready),
      .M           (M),
      .F_dr        (F_dr),
      .F_rtr       (F_rtr),
      .End_of_File (End_of_File),
      .msg_len     (msg_len)
   );

   always #5 clk = ~clk;

   // Expected delivery: the message bytes, then the length trailer when padding is built in.
   function automatic void build_expected(input int len);
      exp_q = msg_q;
`ifdef HES_MSG_FEEDER_PAD_EN
      exp_q.push_back(8'(len));
`endif
   endfunction

   // Drives one whole message with random source/sink pacing and records what the core side saw.
   task automatic stream(input int len, input int pv, input int pr);
      int sent;
      bit last_acc;
      rx_q.delete();
      both_hi = 0; timeout = 1; rdy_after_last = 0; last_acc = 0; sent = 0;
      first_acc = -1; first_xfer = -1; last_xfer = -1; eof_cyc = -1;
      @(negedge clk); start = 1'b1; in_valid = 1'b0; F_rtr = 1'b0;
      @(negedge clk); start = 1'b0;
      for (int cyc = 0; cyc < len * 8 + 100; cyc++) begin
         in_valid = (sent < len) && ($urandom_range(99) < pv);
         in_data  = (sent < len) ? msg_q[sent] : 8'h00;
         in_last  = (sent == len - 1);
         F_rtr    = ($urandom_range(99) < pr);
         #1;
         if (End_of_File && F_dr) both_hi = 1;
         if (last_acc && in_ready) rdy_after_last = 1;
         if (End_of_File) begin
            eof_cyc = cyc; timeout = 0;
            break;
         end
         if (in_valid && in_ready) begin
            if (first_acc < 0) first_acc = cyc;
            if (in_last) last_acc = 1;
            sent++;
         end
         if (F_dr && F_rtr) begin
            if (first_xfer < 0) first_xfer = cyc;
            last_xfer = cyc;
            rx_q.push_back(M);
         end
         @(negedge clk);
      end
      in_valid = 1'b0; F_rtr = 1'b0; in_last = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1; start = 1'b1;
      @(negedge clk); @(negedge clk);
      rst = 1'b0; start = 1'b0; in_valid = 1'b1; in_data = 8'h5a;
      #1;
      total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL reset_in_ready: got %b want 0", in_ready); end
      total++; if (F_dr !== 1'b0) begin bad++; $display("FAIL reset_F_dr: got %b want 0", F_dr); end
      total++; if (End_of_File !== 1'b0) begin bad++; $display("FAIL reset_eof: got %b want 0", End_of_File); end
      total++; if (msg_len !== 16'd0) begin bad++; $display("FAIL reset_msg_len: got %0d want 0", msg_len); end
      total++; if (M !== 8'h00) begin bad++; $display("FAIL reset_M: got %h want 00", M); end
      @(negedge clk); #1;
      total++; if (in_ready !== 1'b0 || msg_len !== 16'd0) begin bad++; $display("FAIL idle_ignores_src: in_ready=%b msg_len=%0d want 0/0", in_ready, msg_len); end
      in_valid = 1'b0;
   endtask

   task automatic test_basic();
      msg_q = '{8'h41, 8'h42, 8'h43};
      build_expected(3);
      stream(3, 100, 100);
      total++; if (timeout) begin bad++; $display("FAIL basic_timeout: got no End_of_File want End_of_File"); end
      total++; if (rx_q != exp_q) begin bad++; $display("FAIL basic_bytes: got %p want %p", rx_q, exp_q); end
      total++; if (msg_len !== 16'd3) begin bad++; $display("FAIL basic_msg_len: got %0d want 3", msg_len); end
      total++; if (first_xfer != first_acc + 1) begin bad++; $display("FAIL basic_latency: got xfer@%0d want %0d", first_xfer, first_acc + 1); end
      total++; if (last_xfer - first_xfer != exp_q.size() - 1) begin bad++; $display("FAIL basic_consecutive: got span %0d want %0d", last_xfer - first_xfer, exp_q.size() - 1); end
      total++; if (eof_cyc != last_xfer + 1) begin bad++; $display("FAIL basic_eof_timing: got %0d want %0d", eof_cyc, last_xfer + 1); end
      total++; if (both_hi) begin bad++; $display("FAIL basic_eof_with_dr: got 1 want 0"); end
   endtask

   task automatic test_backpressure();
      logic [7:0] msg [10];
      int acc = 0;
      bit done = 0;
      rx_q.delete();
      for (int i = 0; i < 10; i++) msg[i] = 8'($urandom);
      msg_q.delete();
      for (int i = 0; i < 10; i++) msg_q.push_back(msg[i]);
      build_expected(10);
      @(negedge clk); start = 1'b1;
      @(negedge clk); start = 1'b0; F_rtr = 1'b0;
      for (int c = 0; c < 12; c++) begin
         in_valid = (acc < 10); in_data = (acc < 10) ? msg[acc] : 8'h00; in_last = (acc == 9);
         #1;
         if (in_valid && in_ready) acc++;
         @(negedge clk);
      end
      in_valid = 1'b1; in_data = msg[acc]; in_last = 1'b0;
      #1;
      total++; if (acc != 8) begin bad++; $display("FAIL bp_accepts: got %0d want 8", acc); end
      total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL bp_in_ready_full: got %b want 0", in_ready); end
      total++; if (F_dr !== 1'b1 || M !== msg[0]) begin bad++; $display("FAIL bp_hold_head: got dr=%b M=%h want 1/%h", F_dr, M, msg[0]); end
      // Full FIFO with a pop this cycle: source must still be refused.
      F_rtr = 1'b1;
      #1;
      total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL full_pushpop_rdy: got %b want 0", in_ready); end
      if (F_dr && F_rtr) rx_q.push_back(M);
      @(negedge clk); F_rtr = 1'b0;
      #1;
      total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL after_pop_rdy: got %b want 1", in_ready); end
      if (in_valid && in_ready) acc++;
      @(negedge clk);
      for (int c = 0; c < 200 && !done; c++) begin
         in_valid = (acc < 10); in_data = (acc < 10) ? msg[acc] : 8'h00; in_last = (acc == 9);
         F_rtr = 1'b1;
         #1;
         if (End_of_File) done = 1;
         else begin
            if (in_valid && in_ready) acc++;
            if (F_dr && F_rtr) rx_q.push_back(M);
            @(negedge clk);
         end
      end
      in_valid = 1'b0; F_rtr = 1'b0; in_last = 1'b0;
      total++; if (!done) begin bad++; $display("FAIL bp_timeout: got no End_of_File want End_of_File"); end
      total++; if (rx_q != exp_q) begin bad++; $display("FAIL bp_order: got %p want %p", rx_q, exp_q); end
      total++; if (msg_len !== 16'd10) begin bad++; $display("FAIL bp_msg_len: got %0d want 10", msg_len); end
   endtask

   task automatic test_restart();
      @(negedge clk); start = 1'b1;
      @(negedge clk); start = 1'b0; F_rtr = 1'b0;
      for (int i = 0; i < 4; i++) begin
         in_valid = 1'b1; in_data = 8'(i + 1); in_last = 1'b0;
         @(negedge clk);
      end
      start = 1'b1; in_data = 8'h55;
      #1;
      total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL restart_rdy_on_start: got %b want 0", in_ready); end
      total++; if (msg_len !== 16'd4) begin bad++; $display("FAIL restart_pre_len: got %0d want 4", msg_len); end
      @(negedge clk); start = 1'b0;
      #1;
      total++; if (msg_len !== 16'd0) begin bad++; $display("FAIL restart_msg_len: got %0d want 0", msg_len); end
      total++; if (F_dr !== 1'b0) begin bad++; $display("FAIL restart_flushed: got F_dr=%b want 0", F_dr); end
      total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL restart_load: got in_ready=%b want 1", in_ready); end
      in_valid = 1'b0;
      msg_q = '{8'hc3, 8'h3c};
      build_expected(2);
      stream(2, 70, 70);
      total++; if (rx_q != exp_q) begin bad++; $display("FAIL restart_bytes: got %p want %p", rx_q, exp_q); end
      total++; if (msg_len !== 16'd2) begin bad++; $display("FAIL restart_len2: got %0d want 2", msg_len); end
   endtask

   task automatic test_random();
      for (int m = 0; m < 12; m++) begin
         int len = $urandom_range(20, 1);
         msg_q.delete();
         for (int i = 0; i < len; i++) msg_q.push_back(8'($urandom));
         build_expected(len);
         stream(len, $urandom_range(100, 30), $urandom_range(100, 30));
         total++; if (timeout) begin bad++; $display("FAIL rand%0d_timeout: got no End_of_File want End_of_File", m); end
         total++; if (rx_q != exp_q) begin bad++; $display("FAIL rand%0d_bytes: got %p want %p", m, rx_q, exp_q); end
         total++; if (msg_len !== 16'(len)) begin bad++; $display("FAIL rand%0d_msg_len: got %0d want %0d", m, msg_len, len); end
         total++; if (eof_cyc != last_xfer + 1) begin bad++; $display("FAIL rand%0d_eof_timing: got %0d want %0d", m, eof_cyc, last_xfer + 1); end
         total++; if (both_hi || rdy_after_last) begin bad++; $display("FAIL rand%0d_flags: got eof_dr=%b rdy_after_last=%b want 0/0", m, both_hi, rdy_after_last); end
      end
      @(negedge clk); @(negedge clk); #1;
      total++; if (End_of_File !== 1'b1 || F_dr !== 1'b0) begin bad++; $display("FAIL eof_hold: got eof=%b dr=%b want 1/0", End_of_File, F_dr); end
   endtask

   task automatic test_wrap();
      msg_q.delete();
      for (int i = 0; i < 256; i++) msg_q.push_back(8'($urandom));
      build_expected(256);
      stream(256, 90, 80);
      total++; if (timeout) begin bad++; $display("FAIL wrap_timeout: got no End_of_File want End_of_File"); end
      total++; if (rx_q != exp_q) begin bad++; $display("FAIL wrap_bytes: got %0d bytes want %0d", rx_q.size(), exp_q.size()); end
      total++; if (msg_len !== 16'd256) begin bad++; $display("FAIL wrap_msg_len: got %0d want 256", msg_len); end
      total++; if (both_hi) begin bad++; $display("FAIL wrap_eof_with_dr: got 1 want 0"); end
   endtask

   task automatic test_rst_in_eof();
      #1;
      total++; if (End_of_File !== 1'b1) begin bad++; $display("FAIL pre_rst_eof: got %b want 1", End_of_File); end
      @(negedge clk); rst = 1'b1; start = 1'b1;
      @(negedge clk); rst = 1'b0; start = 1'b0; in_valid = 1'b1;
      #1;
      total++; if (End_of_File !== 1'b0 || F_dr !== 1'b0 || in_ready !== 1'b0) begin bad++; $display("FAIL rst_eof_flags: got eof=%b dr=%b rdy=%b want 0/0/0", End_of_File, F_dr, in_ready); end
      total++; if (msg_len !== 16'd0 || M !== 8'h00) begin bad++; $display("FAIL rst_eof_vals: got len=%0d M=%h want 0/00", msg_len, M); end
      @(negedge clk); #1;
      total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL rst_over_start_idle: got in_ready=%b want 0", in_ready); end
      in_valid = 1'b0;
   endtask

   initial begin
      test_reset();
      test_basic();
      test_backpressure();
      test_restart();
      test_random();
      test_wrap();
      test_rst_in_eof();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
